// File: rtl/win_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : win_sched                                               |
// | Description: Round-robin window scheduler. Grants one requester a    |
// |              window of LEN cycles (0 treated as 1), then a one-cycle |
// |              FIN with DONE, then IDLE. ABORT ends a window early.    |
// |              Optional macro WIN_SCHED_TMR_EN triplicates the state,  |
// |              counter, latched length and priority pointer with       |
// |              majority voting and per-cycle scrubbing.                |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module win_sched #(
  parameter int NREQ  = 4,
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             SRST_N,
  input  logic [NREQ-1:0]  REQ,
  input  logic [Width-1:0] LEN,
  input  logic             ABORT,
  output logic [NREQ-1:0]  GNT,
  output logic             BUSY,
  output logic [Width-1:0] CNT,
  output logic             DONE,
  output logic             ABORTED
);

  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0]      c_nreq  = (PW+1)'(NREQ);
  localparam logic [PW:0]      c_onep  = (PW+1)'(1);
  localparam logic [Width-1:0] c_one   = Width'(1);
  localparam logic [NREQ-1:0]  c_bit0  = NREQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Voted (or single-copy) view of the protected registers
  state_t           w_state;
  logic [Width-1:0] w_cnt;
  logic [Width-1:0] w_len;
  logic [PW-1:0]    w_ptr;

  // Next values of the protected registers
  state_t           w_state_nx;
  logic [Width-1:0] w_cnt_nx;
  logic [Width-1:0] w_len_nx;
  logic [PW-1:0]    w_ptr_nx;

  // Unprotected output registers
  logic [NREQ-1:0]  r_gnt     = '0;
  logic             r_aborted = 1'b0;
  logic [NREQ-1:0]  w_gnt_nx;
  logic             w_aborted_nx;

  // Arbitration helpers
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_inc;

`ifdef WIN_SCHED_TMR_EN
  (* keep = "true" *) logic [1:0]       r_state_a = '0;
  (* keep = "true" *) logic [1:0]       r_state_b = '0;
  (* keep = "true" *) logic [1:0]       r_state_c = '0;
  (* keep = "true" *) logic [Width-1:0] r_cnt_a   = '0;
  (* keep = "true" *) logic [Width-1:0] r_cnt_b   = '0;
  (* keep = "true" *) logic [Width-1:0] r_cnt_c   = '0;
  (* keep = "true" *) logic [Width-1:0] r_len_a   = '0;
  (* keep = "true" *) logic [Width-1:0] r_len_b   = '0;
  (* keep = "true" *) logic [Width-1:0] r_len_c   = '0;
  (* keep = "true" *) logic [PW-1:0]    r_ptr_a   = '0;
  (* keep = "true" *) logic [PW-1:0]    r_ptr_b   = '0;
  (* keep = "true" *) logic [PW-1:0]    r_ptr_c   = '0;

  assign w_state = state_t'((r_state_a & r_state_b) | (r_state_a & r_state_c) | (r_state_b & r_state_c));
  assign w_cnt   = (r_cnt_a & r_cnt_b) | (r_cnt_a & r_cnt_c) | (r_cnt_b & r_cnt_c);
  assign w_len   = (r_len_a & r_len_b) | (r_len_a & r_len_c) | (r_len_b & r_len_c);
  assign w_ptr   = (r_ptr_a & r_ptr_b) | (r_ptr_a & r_ptr_c) | (r_ptr_b & r_ptr_c);

  // Every copy reloads from the voted next value, scrubbing a single upset in one cycle
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_state_a <= ST_IDLE; r_state_b <= ST_IDLE; r_state_c <= ST_IDLE;
      r_cnt_a   <= '0;      r_cnt_b   <= '0;      r_cnt_c   <= '0;
      r_len_a   <= '0;      r_len_b   <= '0;      r_len_c   <= '0;
      r_ptr_a   <= '0;      r_ptr_b   <= '0;      r_ptr_c   <= '0;
    end else begin
      r_state_a <= w_state_nx; r_state_b <= w_state_nx; r_state_c <= w_state_nx;
      r_cnt_a   <= w_cnt_nx;   r_cnt_b   <= w_cnt_nx;   r_cnt_c   <= w_cnt_nx;
      r_len_a   <= w_len_nx;   r_len_b   <= w_len_nx;   r_len_c   <= w_len_nx;
      r_ptr_a   <= w_ptr_nx;   r_ptr_b   <= w_ptr_nx;   r_ptr_c   <= w_ptr_nx;
    end
  end
`else
  state_t           r_state = ST_IDLE;
  logic [Width-1:0] r_cnt   = '0;
  logic [Width-1:0] r_len   = '0;
  logic [PW-1:0]    r_ptr   = '0;

  assign w_state = r_state;
  assign w_cnt   = r_cnt;
  assign w_len   = r_len;
  assign w_ptr   = r_ptr;

  // Single-copy state register, counter, latched length and priority pointer
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_len   <= w_len_nx;
      r_ptr   <= w_ptr_nx;
    end
  end
`endif

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall
  always_comb begin
    w_win = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (REQ[i]) w_win = PW'(i);
    end
    for (int i = NREQ-1; i >= 0; i--) begin
      if (REQ[i] && (PW'(i) >= w_ptr)) w_win = PW'(i);
    end
    w_inc = {1'b0, w_win} + c_onep;
  end

  // Next-state, counter, length latch and grant decode
  always_comb begin
    w_state_nx   = w_state;
    w_cnt_nx     = w_cnt;
    w_len_nx     = w_len;
    w_ptr_nx     = w_ptr;
    w_gnt_nx     = r_gnt;
    w_aborted_nx = 1'b0;
    case (w_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        w_gnt_nx = '0;
        if (|REQ) begin
          w_state_nx = ST_RUN;
          w_len_nx   = (LEN == '0) ? c_one : LEN;
          w_ptr_nx   = (w_inc == c_nreq) ? '0 : w_inc[PW-1:0];
          w_gnt_nx   = c_bit0 << w_win;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          w_state_nx   = ST_FIN;
          w_cnt_nx     = '0;
          w_gnt_nx     = '0;
          w_aborted_nx = 1'b1;
        end else if (w_cnt == (w_len - c_one)) begin
          w_state_nx = ST_FIN;
          w_cnt_nx   = '0;
          w_gnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt + c_one;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_gnt_nx   = '0;
      end
    endcase
  end

  // Registered grant and abort qualifier
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      r_gnt     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nx;
      r_aborted <= w_aborted_nx;
    end
  end

  assign GNT     = r_gnt;
  assign BUSY    = (w_state == ST_RUN);
  assign DONE    = (w_state == ST_FIN);
  assign CNT     = w_cnt;
  assign ABORTED = r_aborted;

endmodule
`default_nettype wire

// File: doc/win_sched.md
WIN_SCHED -- requirements
Module: win_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter Width, default 8, giving the window counter width in bits.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port SRST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port REQ, input, NREQ bits: per-requester window request, level-sensitive.
REQ-006 The block SHALL have port LEN, input, Width bits: window length in cycles, sampled at grant.
REQ-007 The block SHALL have port ABORT, input, 1 bit: terminates the active window early.
REQ-008 The block SHALL have port GNT, output, NREQ bits: one-hot grant, registered.
REQ-009 The block SHALL have port BUSY, output, 1 bit: a window is active.
REQ-010 The block SHALL have port CNT, output, Width bits: cycle index within the active window.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle end-of-window pulse.
REQ-012 The block SHALL have port ABORTED, output, 1 bit: qualifies DONE, high when the window ended by ABORT.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and FIN, all registered.
REQ-014 IDLE with REQ nonzero at edge t SHALL give RUN at t+1, with GNT one-hot to the winner, BUSY=1, CNT=0, and LEN latched.
REQ-015 Arbitration SHALL be round-robin: the search starts at the index after the last granted requester and wraps modulo NREQ.
REQ-016 After reset, requester 0 SHALL have highest priority.
REQ-017 In RUN, CNT SHALL increment by 1 each cycle, with no wrap beyond the latched length.
REQ-018 A latched LEN of 0 SHALL be treated as 1.
REQ-019 When CNT equals (latched length minus 1) in RUN, the next state SHALL be FIN.
REQ-020 A window of length L SHALL therefore hold GNT for exactly L cycles.
REQ-021 In FIN, GNT and BUSY SHALL be 0, DONE SHALL be 1 for exactly one cycle, CNT SHALL be 0, and the next state SHALL be IDLE.
REQ-022 The minimum gap between consecutive grants SHALL be 2 cycles (FIN, IDLE).
REQ-023 ABORT high in RUN SHALL force FIN on the next edge with ABORTED=1 during FIN.
REQ-024 ABORTED SHALL be 0 in all other cycles.
REQ-025 ABORT SHALL have no effect in IDLE or FIN.
REQ-026 ABORT coinciding with the last count SHALL still assert ABORTED=1.
REQ-027 Deassertion of the granted REQ during RUN SHALL be ignored; the window SHALL run to length or ABORT.
REQ-028 LEN changes after the grant edge SHALL have no effect on the active window.
REQ-029 GNT SHALL never have more than one bit set.
REQ-030 The last-granted pointer SHALL update on the grant edge.

Reset
REQ-031 SRST_N low at a rising edge SHALL force the following, overriding all other inputs including mid-window: IDLE state, GNT=0, BUSY=0, CNT=0, DONE=0, ABORTED=0, priority pointer to requester 0.
REQ-032 No DONE pulse SHALL be generated for a window cut off by reset.
REQ-033 The registers SHALL also power up to the reset values via initial values.

Configuration
REQ-034 When macro WIN_SCHED_TMR_EN is defined, the FSM state, CNT, latched length and priority pointer SHALL be triplicated, preserved against synthesis merging, and bit-wise majority-voted.
REQ-035 With WIN_SCHED_TMR_EN defined, each copy SHALL reload from the voted value every cycle, so a single-copy upset is scrubbed in one cycle.
REQ-036 Without WIN_SCHED_TMR_EN, single copies SHALL be used.
REQ-037 Port-level behaviour SHALL be identical with and without WIN_SCHED_TMR_EN.

Verification
REQ-038 Scenario: reset, then REQ=0001 and LEN=3 at edge 0 -> GNT=0001 at edges 1-3 with CNT 0,1,2; DONE=1 and ABORTED=0 at edge 4; IDLE at edge 5.
REQ-039 Scenario: REQ=1111 held with LEN=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each 1 cycle, 2 idle cycles between grants.
REQ-040 Scenario: LEN=0 -> one-cycle grant, identical to LEN=1.
REQ-041 Scenario: LEN=10 with ABORT pulsed at CNT=4 -> FIN on the next edge with DONE=1 and ABORTED=1; the next grant goes to the requester after the aborted one.
REQ-042 Scenario: SRST_N low at CNT=5 -> next edge GNT=0, BUSY=0, CNT=0, no DONE; REQ=1010 then grants 0010 first.
REQ-043 Scenario: with WIN_SCHED_TMR_EN defined, force one CNT copy to a wrong value for one cycle -> outputs unchanged and all copies equal on the next edge.
